global_mem_ctrl: RTL and testbench

- Front-end controller for the global-variable RAM (64-entry, combinational read, posedge write) in the WASM CPU flow.
- After reset it zero-initialises every entry.
- It then shares the single RAM between two requesters: the execution core (global.get/global.set) and the host/loader port.
- Per-requester access uses a valid/ready handshake, round-robin arbitration and a registered response.

---
 rtl/global_mem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_global_mem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_mem_ctrl.sv
// Global-variable RAM front end: zero-fills the RAM after reset, then arbitrates
// round-robin between the execution core and the host/loader port.
module global_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  core_req_vld,
    output logic                  core_req_rdy,
    input  logic                  core_req_we,
    input  logic [ADDR_WIDTH-1:0] core_req_addr,
    input  logic [DATA_WIDTH-1:0] core_req_wdata,
    output logic                  core_rsp_vld,
    output logic [DATA_WIDTH-1:0] core_rsp_rdata,
    output logic                  core_rsp_err,

    input  logic                  host_req_vld,
    output logic                  host_req_rdy,
    input  logic                  host_req_we,
    input  logic [ADDR_WIDTH-1:0] host_req_addr,
    input  logic [DATA_WIDTH-1:0] host_req_wdata,
    output logic                  host_rsp_vld,
    output logic [DATA_WIDTH-1:0] host_rsp_rdata,
    output logic                  host_rsp_err,

    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,

    output logic                  init_done
);

    localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {StInit, StServe} state_e;
    typedef enum logic {PortCore, PortHost} port_e;

    state_e                  state_q, state_d;
    port_e                   last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic                    init_done_q, init_done_d;

    logic                    core_rsp_vld_q, core_rsp_vld_d;
    logic                    core_rsp_err_q, core_rsp_err_d;
    logic [DATA_WIDTH-1:0]   core_rsp_rdata_q, core_rsp_rdata_d;
    logic                    host_rsp_vld_q, host_rsp_vld_d;
    logic                    host_rsp_err_q, host_rsp_err_d;
    logic [DATA_WIDTH-1:0]   host_rsp_rdata_q, host_rsp_rdata_d;

    logic                    core_gnt, host_gnt, any_gnt;
    logic                    sel_we, sel_oor;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [DATA_WIDTH-1:0]   rsp_data;

    // Grant is combinational from this cycle's valids; ties go to the port not granted last.
    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (state_q == StServe) begin
            if (core_req_vld && host_req_vld) begin
                if (last_grant_q == PortHost) begin
                    core_gnt = 1'b1;
                end else begin
                    host_gnt = 1'b1;
                end
            end else if (core_req_vld) begin
                core_gnt = 1'b1;
            end else if (host_req_vld) begin
                host_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        any_gnt   = core_gnt | host_gnt;
        sel_we    = host_gnt ? host_req_we    : core_req_we;
        sel_addr  = host_gnt ? host_req_addr  : core_req_addr;
        sel_wdata = host_gnt ? host_req_wdata : core_req_wdata;
        sel_oor   = ({1'b0, sel_addr} >= DepthExt);
        rsp_data  = (sel_we || sel_oor) ? '0 : mem_rd_data;
    end

    always_comb begin
        mem_we      = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_rd_addr = '0;
        if (state_q == StInit) begin
            mem_we      = 1'b1;
            mem_wr_addr = init_cnt_q;
        end else if (any_gnt) begin
            if (sel_we) begin
                if (!sel_oor) begin
                    mem_we      = 1'b1;
                    mem_wr_addr = sel_addr;
                    mem_wr_data = sel_wdata;
                end
            end else begin
                mem_rd_addr = sel_addr;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        init_done_d  = init_done_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LastIdx) begin
                    state_d     = StServe;
                    init_cnt_d  = '0;
                    init_done_d = 1'b1;
                end
            end
            StServe: begin
                if (core_gnt) begin
                    last_grant_d = PortCore;
                end else if (host_gnt) begin
                    last_grant_d = PortHost;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Responses are single-cycle pulses; rdata only moves when a response is issued.
    always_comb begin
        core_rsp_vld_d   = core_gnt;
        core_rsp_err_d   = core_gnt & sel_oor;
        core_rsp_rdata_d = core_gnt ? rsp_data : core_rsp_rdata_q;
        host_rsp_vld_d   = host_gnt;
        host_rsp_err_d   = host_gnt & sel_oor;
        host_rsp_rdata_d = host_gnt ? rsp_data : host_rsp_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StInit;
            init_cnt_q       <= '0;
            init_done_q      <= 1'b0;
            last_grant_q     <= PortHost;
            core_rsp_vld_q   <= 1'b0;
            core_rsp_err_q   <= 1'b0;
            core_rsp_rdata_q <= '0;
            host_rsp_vld_q   <= 1'b0;
            host_rsp_err_q   <= 1'b0;
            host_rsp_rdata_q <= '0;
        end else begin
            state_q          <= state_d;
            init_cnt_q       <= init_cnt_d;
            init_done_q      <= init_done_d;
            last_grant_q     <= last_grant_d;
            core_rsp_vld_q   <= core_rsp_vld_d;
            core_rsp_err_q   <= core_rsp_err_d;
            core_rsp_rdata_q <= core_rsp_rdata_d;
            host_rsp_vld_q   <= host_rsp_vld_d;
            host_rsp_err_q   <= host_rsp_err_d;
            host_rsp_rdata_q <= host_rsp_rdata_d;
        end
    end

    assign core_req_rdy   = core_gnt;
    assign host_req_rdy   = host_gnt;
    assign core_rsp_vld   = core_rsp_vld_q;
    assign core_rsp_err   = core_rsp_err_q;
    assign core_rsp_rdata = core_rsp_rdata_q;
    assign host_rsp_vld   = host_rsp_vld_q;
    assign host_rsp_err   = host_rsp_err_q;
    assign host_rsp_rdata = host_rsp_rdata_q;
    assign init_done      = init_done_q;

endmodule

// File: tb/tb_global_mem_ctrl.sv
// Directed bench: a 64-entry instance for init/arbitration/reset and a 48-entry
// instance for out-of-range handling, each driving its own behavioural RAM.
module tb_global_mem_ctrl;

    localparam int AW = 6;
    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic prefill;

    // Instance A (DEPTH=64)
    logic          rst;
    logic          core_req_vld, core_req_rdy, core_req_we;
    logic [AW-1:0] core_req_addr;
    logic [DW-1:0] core_req_wdata, core_rsp_rdata;
    logic          core_rsp_vld, core_rsp_err;
    logic          host_req_vld, host_req_rdy, host_req_we;
    logic [AW-1:0] host_req_addr;
    logic [DW-1:0] host_req_wdata, host_rsp_rdata;
    logic          host_rsp_vld, host_rsp_err;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [DW-1:0] mem_rd_data, mem_wr_data;
    logic          mem_we, init_done;
    logic [DW-1:0] ram_a [64];

    // Instance B (DEPTH=48)
    logic          b_rst;
    logic          b_core_req_vld, b_core_req_rdy, b_core_req_we;
    logic [AW-1:0] b_core_req_addr;
    logic [DW-1:0] b_core_req_wdata, b_core_rsp_rdata;
    logic          b_core_rsp_vld, b_core_rsp_err;
    logic          b_host_req_vld, b_host_req_rdy, b_host_req_we;
    logic [AW-1:0] b_host_req_addr;
    logic [DW-1:0] b_host_req_wdata, b_host_rsp_rdata;
    logic          b_host_rsp_vld, b_host_rsp_err;
    logic [AW-1:0] b_mem_rd_addr, b_mem_wr_addr;
    logic [DW-1:0] b_mem_rd_data, b_mem_wr_data;
    logic          b_mem_we, b_init_done;
    logic [DW-1:0] ram_b [64];

    global_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64)) u_dut_a (
        .clk(clk), .rst(rst),
        .core_req_vld(core_req_vld), .core_req_rdy(core_req_rdy), .core_req_we(core_req_we),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_rsp_vld(core_rsp_vld), .core_rsp_rdata(core_rsp_rdata), .core_rsp_err(core_rsp_err),
        .host_req_vld(host_req_vld), .host_req_rdy(host_req_rdy), .host_req_we(host_req_we),
        .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
        .host_rsp_vld(host_rsp_vld), .host_rsp_rdata(host_rsp_rdata), .host_rsp_err(host_rsp_err),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_we(mem_we),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .init_done(init_done)
    );

    global_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(48)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .core_req_vld(b_core_req_vld), .core_req_rdy(b_core_req_rdy),
        .core_req_we(b_core_req_we), .core_req_addr(b_core_req_addr),
        .core_req_wdata(b_core_req_wdata), .core_rsp_vld(b_core_rsp_vld),
        .core_rsp_rdata(b_core_rsp_rdata), .core_rsp_err(b_core_rsp_err),
        .host_req_vld(b_host_req_vld), .host_req_rdy(b_host_req_rdy),
        .host_req_we(b_host_req_we), .host_req_addr(b_host_req_addr),
        .host_req_wdata(b_host_req_wdata), .host_rsp_vld(b_host_rsp_vld),
        .host_rsp_rdata(b_host_rsp_rdata), .host_rsp_err(b_host_rsp_err),
        .mem_rd_addr(b_mem_rd_addr), .mem_rd_data(b_mem_rd_data), .mem_we(b_mem_we),
        .mem_wr_addr(b_mem_wr_addr), .mem_wr_data(b_mem_wr_data), .init_done(b_init_done)
    );

    // RAMs start filled with non-zero junk so zeroing and rdata masking are observable.
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < 64; i++) begin
                ram_a[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
                ram_b[i] <= 64'h5A5A_0000_0000_0000 | 64'(i);
            end
        end else begin
            if (mem_we) ram_a[mem_wr_addr] <= mem_wr_data;
            if (b_mem_we) ram_b[b_mem_wr_addr] <= b_mem_wr_data;
        end
    end
    assign mem_rd_data   = ram_a[mem_rd_addr];
    assign b_mem_rd_data = ram_b[b_mem_rd_addr];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic exp_core, prev_core, prev_host;
    int   core_seen, host_seen, core_rsp_seen, host_rsp_seen;

    initial begin
        prefill = 1'b1;
        rst = 1'b1;  b_rst = 1'b1;
        core_req_vld = 1'b0; core_req_we = 1'b0; core_req_addr = '0; core_req_wdata = '0;
        host_req_vld = 1'b0; host_req_we = 1'b0; host_req_addr = '0; host_req_wdata = '0;
        b_core_req_vld = 1'b0; b_core_req_we = 1'b0; b_core_req_addr = '0;
        b_core_req_wdata = '0;
        b_host_req_vld = 1'b0; b_host_req_we = 1'b0; b_host_req_addr = '0;
        b_host_req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        prefill = 1'b0;

        // Reset state
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_core_rsp_vld", 64'(core_rsp_vld), 64'd0);
        chk("rst_host_rsp_vld", 64'(host_rsp_vld), 64'd0);
        chk("rst_core_rsp_err", 64'(core_rsp_err), 64'd0);
        chk("rst_core_rdata", core_rsp_rdata, 64'd0);
        chk("rst_host_rdata", host_rsp_rdata, 64'd0);

        // Core write held through INIT; must not be accepted until SERVE
        rst = 1'b0; b_rst = 1'b0;
        core_req_vld = 1'b1; core_req_we = 1'b1; core_req_addr = 6'd5;
        core_req_wdata = 64'h1122_3344_5566_7788;
        #1;
        for (int i = 0; i < 64; i++) begin
            chk("init_we", 64'(mem_we), 64'd1);
            chk("init_addr", 64'(mem_wr_addr), 64'(i));
            chk("init_data", mem_wr_data, 64'd0);
            chk("init_core_rdy", 64'(core_req_rdy), 64'd0);
            chk("init_host_rdy", 64'(host_req_rdy), 64'd0);
            chk("init_done_low", 64'(init_done), 64'd0);
            @(negedge clk); #1;
        end

        // Cycle 65: SERVE, core write accepted
        chk("init_done_high", 64'(init_done), 64'd1);
        chk("wr_core_rdy", 64'(core_req_rdy), 64'd1);
        chk("wr_host_rdy", 64'(host_req_rdy), 64'd0);
        chk("wr_mem_we", 64'(mem_we), 64'd1);
        chk("wr_mem_addr", 64'(mem_wr_addr), 64'd5);
        chk("wr_mem_data", mem_wr_data, 64'h1122_3344_5566_7788);

        @(negedge clk);
        chk("wr_rsp_vld", 64'(core_rsp_vld), 64'd1);
        chk("wr_rsp_err", 64'(core_rsp_err), 64'd0);
        chk("wr_rsp_rdata", core_rsp_rdata, 64'd0);
        core_req_we = 1'b0;
        #1;
        chk("rd_core_rdy", 64'(core_req_rdy), 64'd1);
        chk("rd_mem_we", 64'(mem_we), 64'd0);
        chk("rd_mem_addr", 64'(mem_rd_addr), 64'd5);

        @(negedge clk);
        chk("rd_rsp_vld", 64'(core_rsp_vld), 64'd1);
        chk("rd_rsp_rdata", core_rsp_rdata, 64'h1122_3344_5566_7788);
        chk("rd_rsp_err", 64'(core_rsp_err), 64'd0);
        core_req_vld = 1'b0;
        #1;
        chk("idle_mem_we", 64'(mem_we), 64'd0);
        chk("idle_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("idle_core_rdy", 64'(core_req_rdy), 64'd0);

        @(negedge clk);
        chk("hold_rsp_vld", 64'(core_rsp_vld), 64'd0);
        chk("hold_rdata", core_rsp_rdata, 64'h1122_3344_5566_7788);

        // Host write 63 then core read 63; last grant was core so host wins first
        host_req_vld = 1'b1; host_req_we = 1'b1; host_req_addr = 6'd63;
        host_req_wdata = 64'hDEAD;
        core_req_vld = 1'b1; core_req_we = 1'b0; core_req_addr = 6'd63;
        #1;
        chk("raw_host_rdy", 64'(host_req_rdy), 64'd1);
        chk("raw_core_rdy", 64'(core_req_rdy), 64'd0);
        chk("raw_mem_we", 64'(mem_we), 64'd1);
        chk("raw_wr_addr", 64'(mem_wr_addr), 64'd63);
        chk("raw_wr_data", mem_wr_data, 64'hDEAD);

        @(negedge clk);
        chk("raw_host_rsp_vld", 64'(host_rsp_vld), 64'd1);
        chk("raw_host_rsp_err", 64'(host_rsp_err), 64'd0);
        chk("raw_host_rdata", host_rsp_rdata, 64'd0);
        chk("raw_core_rsp_idle", 64'(core_rsp_vld), 64'd0);
        host_req_vld = 1'b0;
        #1;
        chk("raw_core_rdy2", 64'(core_req_rdy), 64'd1);
        chk("raw_rd_addr", 64'(mem_rd_addr), 64'd63);

        @(negedge clk);
        chk("raw_core_rsp_vld", 64'(core_rsp_vld), 64'd1);
        chk("raw_core_rdata", core_rsp_rdata, 64'hDEAD);
        chk("raw_host_rsp_idle", 64'(host_rsp_vld), 64'd0);

        // Reset in the cycle a core read is accepted
        core_req_addr = 6'd5;
        rst = 1'b1;
        #1;
        chk("mid_rst_core_rdy", 64'(core_req_rdy), 64'd1);

        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_rsp_dropped", 64'(core_rsp_vld), 64'd0);
        chk("mid_rst_init_done", 64'(init_done), 64'd0);
        host_req_vld = 1'b1; host_req_we = 1'b0; host_req_addr = 6'd63;
        #1;
        for (int i = 0; i < 64; i++) begin
            chk("reinit_we", 64'(mem_we), 64'd1);
            chk("reinit_addr", 64'(mem_wr_addr), 64'(i));
            chk("reinit_core_rdy", 64'(core_req_rdy), 64'd0);
            chk("reinit_host_rdy", 64'(host_req_rdy), 64'd0);
            @(negedge clk); #1;
        end

        // Contention: after reset last_grant is host, so core goes first then alternate
        exp_core = 1'b1; prev_core = 1'b0; prev_host = 1'b0;
        core_seen = 0; host_seen = 0; core_rsp_seen = 0; host_rsp_seen = 0;
        for (int k = 0; k < 20; k++) begin
            chk("cont_core_rsp_vld", 64'(core_rsp_vld), 64'(prev_core));
            chk("cont_host_rsp_vld", 64'(host_rsp_vld), 64'(prev_host));
            if (core_rsp_vld) begin
                core_rsp_seen++;
                chk("cont_core_rdata", core_rsp_rdata, 64'd0);
            end
            if (host_rsp_vld) begin
                host_rsp_seen++;
                chk("cont_host_rdata", host_rsp_rdata, 64'd0);
            end
            chk("cont_core_rdy", 64'(core_req_rdy), 64'(exp_core));
            chk("cont_host_rdy", 64'(host_req_rdy), 64'(!exp_core));
            core_seen += int'(core_req_rdy);
            host_seen += int'(host_req_rdy);
            prev_core = exp_core;
            prev_host = !exp_core;
            exp_core  = !exp_core;
            @(negedge clk); #1;
        end
        core_req_vld = 1'b0; host_req_vld = 1'b0;
        chk("cont_last_core_rsp", 64'(core_rsp_vld), 64'(prev_core));
        chk("cont_last_host_rsp", 64'(host_rsp_vld), 64'(prev_host));
        core_rsp_seen += int'(core_rsp_vld);
        host_rsp_seen += int'(host_rsp_vld);
        chk("cont_core_grants", 64'(core_seen), 64'd10);
        chk("cont_host_grants", 64'(host_seen), 64'd10);
        chk("cont_core_rsps", 64'(core_rsp_seen), 64'd10);
        chk("cont_host_rsps", 64'(host_rsp_seen), 64'd10);

        // Out-of-range on the 48-entry instance
        @(negedge clk);
        chk("b_init_done", 64'(b_init_done), 64'd1);
        b_host_req_vld = 1'b1; b_host_req_we = 1'b1; b_host_req_addr = 6'd50;
        b_host_req_wdata = 64'hBEEF;
        #1;
        chk("oor_wr_rdy", 64'(b_host_req_rdy), 64'd1);
        chk("oor_wr_mem_we", 64'(b_mem_we), 64'd0);

        @(negedge clk);
        chk("oor_wr_rsp_vld", 64'(b_host_rsp_vld), 64'd1);
        chk("oor_wr_rsp_err", 64'(b_host_rsp_err), 64'd1);
        chk("oor_wr_rdata", b_host_rsp_rdata, 64'd0);
        b_host_req_we = 1'b0;
        #1;
        chk("oor_rd_rdy", 64'(b_host_req_rdy), 64'd1);

        @(negedge clk);
        chk("oor_rd_rsp_vld", 64'(b_host_rsp_vld), 64'd1);
        chk("oor_rd_rsp_err", 64'(b_host_rsp_err), 64'd1);
        chk("oor_rd_rdata", b_host_rsp_rdata, 64'd0);
        b_host_req_we = 1'b1; b_host_req_addr = 6'd47; b_host_req_wdata = 64'h4747;
        #1;
        chk("edge_wr_mem_we", 64'(b_mem_we), 64'd1);
        chk("edge_wr_addr", 64'(b_mem_wr_addr), 64'd47);

        @(negedge clk);
        chk("edge_wr_rsp_err", 64'(b_host_rsp_err), 64'd0);
        b_host_req_we = 1'b0;

        @(negedge clk);
        chk("edge_rd_rsp_vld", 64'(b_host_rsp_vld), 64'd1);
        chk("edge_rd_rsp_err", 64'(b_host_rsp_err), 64'd0);
        chk("edge_rd_rdata", b_host_rsp_rdata, 64'h4747);
        b_host_req_vld = 1'b0;

        @(negedge clk);
        chk("b_idle_rsp_vld", 64'(b_host_rsp_vld), 64'd0);
        chk("b_idle_rsp_err", 64'(b_host_rsp_err), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
